// File: rtl/ball_if.sv
// ball_if: bundles the ball controller's run/collision/point inputs and its
// position/direction outputs. "master" drives the inputs (datapath side),
// "slave" is the ball controller itself.
interface ball_if;
  logic       en;
  logic [1:0] paddle_collision;
  logic       wall_collision;
  logic       p1_point;
  logic       p2_point;
  logic [5:0] bx;
  logic [5:0] by;
  logic       dir_x;
  logic       dir_y;
  logic       ball_active;

  modport master (
    output en, paddle_collision, wall_collision, p1_point, p2_point,
    input  bx, by, dir_x, dir_y, ball_active
  );

  modport slave (
    input  en, paddle_collision, wall_collision, p1_point, p2_point,
    output bx, by, dir_x, dir_y, ball_active
  );
endinterface

// File: rtl/ball_ctrl.sv
// ball_ctrl: Pong ball motion controller. Holds the ball at the centre for
// SERVE_TICKS movement ticks after reset or a point, then steps the ball one
// cell per tick, bouncing off paddles, walls and the grid edges.
// Optional macro BALL_SPEEDUP_EN: each paddle hit shortens the tick period by
// one cycle down to MIN_DIV; a point restores TICK_DIV.
module ball_ctrl #(
  parameter int TICK_DIV    = 4,
  parameter int MIN_DIV     = 2,
  parameter int SERVE_TICKS = 2
) (
  input logic   clk,
  input logic   rst,
  ball_if.slave bus
);

  localparam int CW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(SERVE_TICKS + 1);

`ifdef BALL_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  typedef enum logic {SERVE = 1'b0, MOVE = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] div_reg;
  logic [SW-1:0] serve_cnt_reg;
  logic [5:0]    bx_reg, by_reg;
  logic          dir_x_reg, dir_y_reg;

  logic          tick, point, serve_done, move_tick, hit;
  logic          dx_next, dy_next;
  logic [5:0]    bx_next, by_next;

  // A point only counts while the ball is in play and the controller runs.
  assign tick       = bus.en && (cnt_reg == div_reg - CW'(1));
  assign point      = bus.en && (state_reg == MOVE) && (bus.p1_point || bus.p2_point);
  assign serve_done = tick && (state_reg == SERVE) && (serve_cnt_reg == SW'(SERVE_TICKS - 1));
  assign move_tick  = tick && (state_reg == MOVE);
  assign hit        = bus.paddle_collision[0];  // 01 or 11

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= SERVE;
    else     state_reg <= state_next;
  end

  // Next state: serve ends on the last serve tick, a point returns to serve.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SERVE: if (serve_done) state_next = MOVE;
      MOVE:  if (point)      state_next = SERVE;
      default: state_next = SERVE;
    endcase
  end

  // Output decode: ball is in play only in MOVE.
  always_comb begin
    bus.ball_active = (state_reg == MOVE);
  end

  // Resolve directions (paddle, wall, then grid edge) and step the ball.
  always_comb begin
    dx_next = dir_x_reg;
    dy_next = dir_y_reg;
    if (bus.paddle_collision == 2'b01)      dx_next = 1'b1;
    else if (bus.paddle_collision == 2'b11) dx_next = 1'b0;
    if (bus.wall_collision && by_reg == 6'd0)       dy_next = 1'b1;
    else if (bus.wall_collision && by_reg == 6'd63) dy_next = 1'b0;
    // Never wrap: a step past either edge reverses instead.
    if (dx_next && bx_reg == 6'd63)       dx_next = 1'b0;
    else if (!dx_next && bx_reg == 6'd0)  dx_next = 1'b1;
    if (dy_next && by_reg == 6'd63)       dy_next = 1'b0;
    else if (!dy_next && by_reg == 6'd0)  dy_next = 1'b1;
    bx_next = dx_next ? bx_reg + 6'd1 : bx_reg - 6'd1;
    by_next = dy_next ? by_reg + 6'd1 : by_reg - 6'd1;
  end

  // Tick and serve counters; a point restarts both from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg       <= '0;
      serve_cnt_reg <= '0;
    end else if (bus.en) begin
      if (point) begin
        cnt_reg       <= '0;
        serve_cnt_reg <= '0;
      end else begin
        cnt_reg <= tick ? '0 : cnt_reg + CW'(1);
        if (tick && state_reg == SERVE)
          serve_cnt_reg <= serve_done ? '0 : serve_cnt_reg + SW'(1);
      end
    end
  end

  // Position and direction: recentre on a point, step on each MOVE tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bx_reg    <= 6'd32;
      by_reg    <= 6'd32;
      dir_x_reg <= 1'b1;
      dir_y_reg <= 1'b1;
    end else if (point) begin
      bx_reg    <= 6'd32;
      by_reg    <= 6'd32;
      dir_x_reg <= bus.p2_point;  // p1 alone serves left, p2 or both serve right
      dir_y_reg <= 1'b1;
    end else if (move_tick) begin
      bx_reg    <= bx_next;
      by_reg    <= by_next;
      dir_x_reg <= dx_next;
      dir_y_reg <= dy_next;
    end
  end

  // Tick divisor: paddle hits speed the ball up; the counter wraps on the same
  // edge, so the shorter period applies from the next tick on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg <= CW'(TICK_DIV);
    end else if (point) begin
      div_reg <= CW'(TICK_DIV);
    end else if (SPEEDUP && move_tick && hit && div_reg > CW'(MIN_DIV)) begin
      div_reg <= div_reg - CW'(1);
    end
  end

  assign bus.bx    = bx_reg;
  assign bus.by    = by_reg;
  assign bus.dir_x = dir_x_reg;
  assign bus.dir_y = dir_y_reg;

endmodule

// File: tb/tb_ball_ctrl.sv
// tb_ball_ctrl: table-driven and hand-written checks of ball_ctrl plus a
// randomized run compared against a cycle-level reference model.
module tb_ball_ctrl;

  localparam int TDIV   = 4;
  localparam int MDIV   = 2;
  localparam int STICKS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ball_if bus();

  ball_ctrl #(.TICK_DIV(TDIV), .MIN_DIV(MDIV), .SERVE_TICKS(STICKS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic       en;
    logic [1:0] pc;
    logic       wall, p1, p2;
    int         n;
    logic [5:0] bx, by;
    logic       dx, dy, act;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(string name, logic en, logic [1:0] pc, logic wall,
                              logic p1, logic p2, int n, logic [5:0] bx,
                              logic [5:0] by, logic dx, logic dy, logic act);
    vec_t v;
    v.name = name; v.en = en; v.pc = pc; v.wall = wall; v.p1 = p1; v.p2 = p2;
    v.n = n; v.bx = bx; v.by = by; v.dx = dx; v.dy = dy; v.act = act;
    return v;
  endfunction

  task automatic set_in(logic en, logic [1:0] pc, logic wall, logic p1, logic p2);
    bus.en = en; bus.paddle_collision = pc; bus.wall_collision = wall;
    bus.p1_point = p1; bus.p2_point = p2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [5:0] ebx, logic [5:0] eby,
                       logic edx, logic edy, logic eact);
    total++;
    if ({bus.bx, bus.by, bus.dir_x, bus.dir_y, bus.ball_active} !== {ebx, eby, edx, edy, eact}) begin
      bad++;
      $display("FAIL %s: got bx=%0d by=%0d dx=%0b dy=%0b act=%0b, want bx=%0d by=%0d dx=%0b dy=%0b act=%0b",
               name, bus.bx, bus.by, bus.dir_x, bus.dir_y, bus.ball_active,
               ebx, eby, edx, edy, eact);
    end
  endtask

  task automatic check_int(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    check("reset_state", 6'd32, 6'd32, 1'b1, 1'b1, 1'b0);
  endtask

  // Hold the given inputs for n movement ticks at serve speed.
  task automatic run_ticks(int n, logic [1:0] pc, logic wall);
    set_in(1'b1, pc, wall, 1'b0, 1'b0);
    for (int i = 0; i < n * TDIV; i++) step();
    set_in(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  // Cycles until bx changes, bounded; an expired bound returns the bound.
  task automatic cycles_to_move(output int n);
    logic [5:0] prev;
    prev = bus.bx;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.bx == prev && n < 64);
  endtask

  // ---------------- reference model (whole-cell, signed velocities) --------
  int m_bx, m_by, m_vx, m_vy, m_act, m_phase, m_serve, m_div;

  task automatic model_reset();
    m_bx = 32; m_by = 32; m_vx = 1; m_vy = 1; m_act = 0;
    m_phase = 0; m_serve = 0; m_div = TDIV;
  endtask

  task automatic model_step(logic en, logic [1:0] pc, logic wall, logic p1, logic p2);
    int nx, ny;
    if (!en) return;
    if (m_act != 0 && (p1 || p2)) begin
      m_bx = 32; m_by = 32; m_vy = 1; m_vx = p2 ? 1 : -1;
      m_act = 0; m_phase = 0; m_serve = 0; m_div = TDIV;
      return;
    end
    if (m_phase != m_div - 1) begin
      m_phase++;
      return;
    end
    m_phase = 0;
    if (m_act == 0) begin
      m_serve++;
      if (m_serve == STICKS) begin
        m_serve = 0;
        m_act = 1;
      end
      return;
    end
    if (pc == 2'b01) m_vx = 1;
    if (pc == 2'b11) m_vx = -1;
    if (wall && m_by == 0)  m_vy = 1;
    if (wall && m_by == 63) m_vy = -1;
    nx = m_bx + m_vx;
    if (nx < 0 || nx > 63) begin m_vx = -m_vx; nx = m_bx + m_vx; end
    ny = m_by + m_vy;
    if (ny < 0 || ny > 63) begin m_vy = -m_vy; ny = m_by + m_vy; end
    m_bx = nx; m_by = ny;
`ifdef BALL_SPEEDUP_EN
    if ((pc == 2'b01 || pc == 2'b11) && m_div > MDIV) m_div--;
`endif
  endtask

  initial begin
    int n;
    logic       r_en, r_wall, r_p1, r_p2;
    logic [1:0] r_pc;

    // Startup, movement, enable, hits and points from a fresh reset.
    vecs[0]  = mk("serve_hold",       1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 7, 6'd32, 6'd32, 1'b1, 1'b1, 1'b0);
    vecs[1]  = mk("serve_exit",       1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1, 6'd32, 6'd32, 1'b1, 1'b1, 1'b1);
    vecs[2]  = mk("pre_first_move",   1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3, 6'd32, 6'd32, 1'b1, 1'b1, 1'b1);
    vecs[3]  = mk("first_move",       1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1, 6'd33, 6'd33, 1'b1, 1'b1, 1'b1);
    vecs[4]  = mk("second_move",      1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4, 6'd34, 6'd34, 1'b1, 1'b1, 1'b1);
    vecs[5]  = mk("en_low_hold",      1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5, 6'd34, 6'd34, 1'b1, 1'b1, 1'b1);
    vecs[6]  = mk("en_resume_phase",  1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4, 6'd35, 6'd35, 1'b1, 1'b1, 1'b1);
    vecs[7]  = mk("right_paddle_hit", 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 4, 6'd34, 6'd36, 1'b0, 1'b1, 1'b1);
    vecs[8]  = mk("wall_mid_ignored", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 4, 6'd33, 6'd37, 1'b0, 1'b1, 1'b1);
    vecs[9]  = mk("p1_point",         1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1, 6'd32, 6'd32, 1'b0, 1'b1, 1'b0);
    vecs[10] = mk("reserve_exit",     1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8, 6'd32, 6'd32, 1'b0, 1'b1, 1'b1);
    vecs[11] = mk("serve_left_move",  1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4, 6'd31, 6'd33, 1'b0, 1'b1, 1'b1);
    vecs[12] = mk("both_points",      1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1, 6'd32, 6'd32, 1'b1, 1'b1, 1'b0);
    vecs[13] = mk("point_in_serve",   1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 8, 6'd32, 6'd32, 1'b1, 1'b1, 1'b1);
    vecs[14] = mk("point_en_low",     1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 2, 6'd32, 6'd32, 1'b1, 1'b1, 1'b1);
    vecs[15] = mk("move_after_en",    1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4, 6'd33, 6'd33, 1'b1, 1'b1, 1'b1);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_in(vecs[i].en, vecs[i].pc, vecs[i].wall, vecs[i].p1, vecs[i].p2);
      for (int k = 0; k < vecs[i].n; k++) step();
      check(vecs[i].name, vecs[i].bx, vecs[i].by, vecs[i].dx, vecs[i].dy, vecs[i].act);
    end

    // Edge and wall bounces along a diagonal run.
    do_reset();
    set_in(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2 * TDIV; k++) step();
    run_ticks(29, 2'b00, 1'b0);
    check("reach_61", 6'd61, 6'd61, 1'b1, 1'b1, 1'b1);
    run_ticks(1, 2'b11, 1'b0);
    check("hit_right_at_61", 6'd60, 6'd62, 1'b0, 1'b1, 1'b1);
    run_ticks(1, 2'b00, 1'b0);
    check("reach_row_63", 6'd59, 6'd63, 1'b0, 1'b1, 1'b1);
    run_ticks(1, 2'b00, 1'b1);
    check("wall_bottom", 6'd58, 6'd62, 1'b0, 1'b0, 1'b1);
    run_ticks(56, 2'b00, 1'b0);
    check("reach_col_2", 6'd2, 6'd6, 1'b0, 1'b0, 1'b1);
    run_ticks(1, 2'b01, 1'b0);
    check("hit_left_at_2", 6'd3, 6'd5, 1'b1, 1'b0, 1'b1);
    run_ticks(5, 2'b00, 1'b0);
    check("reach_row_0", 6'd8, 6'd0, 1'b1, 1'b0, 1'b1);
    run_ticks(1, 2'b00, 1'b1);
    check("wall_top", 6'd9, 6'd1, 1'b1, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a tick period.
    step();
    step();
    #2 rst = 1'b1;
    #1 check("async_reset", 6'd32, 6'd32, 1'b1, 1'b1, 1'b0);
    step();
    rst = 1'b0;
    set_in(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 11; k++) step();
    check("after_reset_hold", 6'd32, 6'd32, 1'b1, 1'b1, 1'b1);
    step();
    check("after_reset_move", 6'd33, 6'd33, 1'b1, 1'b1, 1'b1);

`ifdef BALL_SPEEDUP_EN
    // Repeated left-paddle hits shorten the tick spacing to MIN_DIV.
    do_reset();
    set_in(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    cycles_to_move(n); check_int("speed_first_move", n, 12);
    cycles_to_move(n); check_int("speed_gap1", n, 3);
    cycles_to_move(n); check_int("speed_gap2", n, 2);
    cycles_to_move(n); check_int("speed_gap3", n, 2);
    set_in(1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
    step();
    set_in(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    cycles_to_move(n); check_int("speed_reset_on_point", n, 12);
`else
    do_reset();
    set_in(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    cycles_to_move(n); check_int("fixed_first_move", n, 12);
    cycles_to_move(n); check_int("fixed_gap1", n, 4);
    cycles_to_move(n); check_int("fixed_gap2", n, 4);
`endif

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      r_en   = ($urandom_range(0, 9) != 0);
      r_pc   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      r_wall = ($urandom_range(0, 3) == 0);
      r_p1   = ($urandom_range(0, 79) == 0);
      r_p2   = ($urandom_range(0, 79) == 0);
      set_in(r_en, r_pc, r_wall, r_p1, r_p2);
      model_step(r_en, r_pc, r_wall, r_p1, r_p2);
      step();
      check($sformatf("random_cycle_%0d", c), 6'(m_bx), 6'(m_by),
            (m_vx > 0), (m_vy > 0), (m_act != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
